// File: rtl/bus_uart_pkg.sv
// Shared definitions for the bus-mapped UART: register map, STATUS bits,
// FSM state encodings and the captured bus request.
package bus_uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_TX_BUSY    = 2;
    localparam int ST_RX_VALID   = 3;
    localparam int ST_RX_OVERRUN = 4;

    localparam int DIV_W = 16;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic       {BUS_IDLE, BUS_BUSY} bus_state_t;

    // Only the bits the register file actually decodes are held.
    typedef struct packed {
        logic        wr;
        logic [1:0]  idx;
        logic [15:0] wdata;
        logic [1:0]  wmask;
    } bus_req_t;

    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
        return (d < 16'd4) ? 16'd4 : d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the transmitter; pointers carry an extra wrap bit so full
// and empty are distinguishable. A push while full is taken only with a pop.
module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               wdata,
    input  logic                     pop,
    output logic [7:0]               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign rdata   = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/bus_uart.sv
// Memory-mapped 8N1 UART: single-outstanding bus responder with latency-1
// completion, TX FIFO with back-pressure, and a double-synchronised receiver.
module bus_uart #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_RESET  = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic [3:0]  bus_wmask,
    input  logic        bus_wen,
    input  logic        bus_ren,
    output logic [31:0] bus_rdata,
    output logic        bus_done,
    output logic        uart_tx,
    input  logic        uart_rx
);
    import bus_uart_pkg::*;
    localparam int AW = $clog2(FIFO_DEPTH);

    bus_state_t       bst;
    bus_req_t         req;
    logic [DIV_W-1:0] div;
    logic [31:0]      rd_val;
    logic             accept, data_wr, stall, complete, push, rd_clr;

    logic             fifo_full, fifo_empty;
    logic [7:0]       fifo_rdata;
    logic [AW:0]      fifo_count;

    tx_state_t        tx_st;
    logic [DIV_W-1:0] tx_div, tx_cnt;
    logic [7:0]       tx_sh;
    logic [2:0]       tx_bit;
    logic             tx_end, tx_pop;

    rx_state_t        rx_st;
    logic [2:0]       rx_sync;
    logic [DIV_W-1:0] rx_div, rx_cnt;
    logic [7:0]       rx_sh, rx_byte;
    logic [2:0]       rx_bit;
    logic             rx_s, rx_prev, rx_half, rx_end, rx_valid, rx_overrun;

    logic             bus_unused;
    assign bus_unused = ^{bus_addr[31:4], bus_addr[1:0], bus_wdata[31:16], bus_wmask[3:2], fifo_count};

    assign accept   = (bus_ren || bus_wen) && (bst == BUS_IDLE || bus_done);
    assign data_wr  = req.wr && req.idx == REG_DATA && req.wmask[0];
    // A full FIFO only blocks the write if the transmitter is not freeing a slot now.
    assign stall    = data_wr && fifo_full && !tx_pop;
    assign complete = (bst == BUS_BUSY) && !stall;
    assign push     = complete && data_wr;
    assign rd_clr   = complete && !req.wr && req.idx == REG_DATA;

    always_comb begin
        rd_val = '0;
        case (req.idx)
            REG_DATA:   if (rx_valid) rd_val = {23'b0, 1'b1, rx_byte};
            REG_STATUS: begin
                rd_val[ST_TX_FULL]    = fifo_full;
                rd_val[ST_TX_EMPTY]   = fifo_empty;
                rd_val[ST_TX_BUSY]    = (tx_st != TX_IDLE);
                rd_val[ST_RX_VALID]   = rx_valid;
                rd_val[ST_RX_OVERRUN] = rx_overrun;
            end
            REG_DIV:    rd_val[DIV_W-1:0] = div;
            default:    rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bst       <= BUS_IDLE;
            req       <= '0;
            bus_done  <= 1'b0;
            bus_rdata <= '0;
        end else begin
            bus_done  <= complete;
            bus_rdata <= (complete && !req.wr) ? rd_val : '0;
            if (complete) bst <= BUS_IDLE;
            if (accept) begin
                bst <= BUS_BUSY;
                req <= '{wr: bus_wen, idx: bus_addr[3:2], wdata: bus_wdata[15:0], wmask: bus_wmask[1:0]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div <= DIV_W'(DIV_RESET);
        end else if (complete && req.wr && req.idx == REG_DIV) begin
            if (req.wmask[0]) div[7:0]  <= req.wdata[7:0];
            if (req.wmask[1]) div[15:8] <= req.wdata[15:8];
        end
    end

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (req.wdata[7:0]),
        .pop   (tx_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tx_end = (tx_cnt == tx_div - 16'd1);
    // Popping straight out of STOP keeps back-to-back frames gap-free.
    assign tx_pop = !fifo_empty && (tx_st == TX_IDLE || (tx_st == TX_STOP && tx_end));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_st   <= TX_IDLE;
            uart_tx <= 1'b1;
            tx_div  <= 16'd4;
            tx_cnt  <= '0;
            tx_sh   <= '0;
            tx_bit  <= '0;
        end else if (tx_pop) begin
            tx_st   <= TX_START;
            uart_tx <= 1'b0;
            tx_sh   <= fifo_rdata;
            tx_div  <= eff_div(div);
            tx_cnt  <= '0;
        end else begin
            case (tx_st)
                TX_IDLE: uart_tx <= 1'b1;
                TX_START: begin
                    tx_cnt <= tx_end ? '0 : tx_cnt + 16'd1;
                    if (tx_end) begin
                        tx_st   <= TX_DATA;
                        uart_tx <= tx_sh[0];
                        tx_bit  <= '0;
                    end
                end
                TX_DATA: begin
                    tx_cnt <= tx_end ? '0 : tx_cnt + 16'd1;
                    if (tx_end) begin
                        if (tx_bit == 3'd7) begin
                            tx_st   <= TX_STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            tx_sh   <= tx_sh >> 1;
                            uart_tx <= tx_sh[1];
                            tx_bit  <= tx_bit + 3'd1;
                        end
                    end
                end
                TX_STOP: begin
                    tx_cnt <= tx_end ? '0 : tx_cnt + 16'd1;
                    if (tx_end) tx_st <= TX_IDLE;
                end
                default: tx_st <= TX_IDLE;
            endcase
        end
    end

    // rx_sync[1] is the synchronised line; rx_sync[2] delays it for edge detect.
    assign rx_s    = rx_sync[1];
    assign rx_prev = rx_sync[2];
    assign rx_half = (rx_cnt == (rx_div >> 1) - 16'd1);
    assign rx_end  = (rx_cnt == rx_div - 16'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_sync    <= 3'b111;
            rx_st      <= RX_IDLE;
            rx_div     <= 16'd4;
            rx_cnt     <= '0;
            rx_sh      <= '0;
            rx_bit     <= '0;
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[1:0], uart_rx};
            if (rd_clr) begin
                rx_valid   <= 1'b0;
                rx_overrun <= 1'b0;
            end
            case (rx_st)
                RX_IDLE: if (rx_prev && !rx_s) begin
                    rx_st  <= RX_START;
                    rx_cnt <= '0;
                    rx_div <= eff_div(div);
                end
                RX_START: begin
                    rx_cnt <= rx_half ? '0 : rx_cnt + 16'd1;
                    if (rx_half) begin
                        rx_st  <= rx_s ? RX_IDLE : RX_DATA;
                        rx_bit <= '0;
                    end
                end
                RX_DATA: begin
                    rx_cnt <= rx_end ? '0 : rx_cnt + 16'd1;
                    if (rx_end) begin
                        rx_sh  <= {rx_s, rx_sh[7:1]};
                        rx_bit <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_st <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    rx_cnt <= rx_end ? '0 : rx_cnt + 16'd1;
                    if (rx_end) begin
                        rx_st <= RX_IDLE;
                        if (rx_s) begin
                            rx_byte  <= rx_sh;
                            rx_valid <= 1'b1;
                            if (rx_valid && !rd_clr) rx_overrun <= 1'b1;
                        end
                    end
                end
                default: rx_st <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_uart.sv
// Directed bench for bus_uart: register vector table plus hand sequences for
// TX framing, FIFO back-pressure, RX/overrun, request capture and reset abort.
module tb_bus_uart;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] bus_addr = '0, bus_wdata = '0;
    logic [3:0]  bus_wmask = '0;
    logic        bus_wen = 1'b0, bus_ren = 1'b0, uart_rx = 1'b1;
    logic [31:0] bus_rdata;
    logic        bus_done, uart_tx;

    int n_chk = 0, n_fail = 0;

    bus_uart dut (
        .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wmask(bus_wmask), .bus_wen(bus_wen), .bus_ren(bus_ren),
        .bus_rdata(bus_rdata), .bus_done(bus_done), .uart_tx(uart_tx), .uart_rx(uart_rx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request at a negedge, drop it after acceptance, and report the
    // number of cycles until bus_done is seen (bounded).
    task automatic bus_xfer(input bit wr, input logic [1:0] idx, input logic [31:0] wd,
                            input logic [3:0] wm, output logic [31:0] rd, output int lat);
        @(negedge clk);
        bus_addr = {28'h0, idx, 2'b00}; bus_wdata = wd; bus_wmask = wm;
        bus_wen = wr; bus_ren = !wr;
        @(negedge clk);
        bus_wen = 1'b0; bus_ren = 1'b0;
        lat = 0;
        while (bus_done !== 1'b1 && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        rd = bus_rdata;
    endtask

    task automatic check_frame(input string name, input logic [7:0] exp);
        int t = 0;
        logic [9:0] got;
        while (uart_tx !== 1'b0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 4000) begin
            chk({name, "_timeout"}, 32'(t), 0);
            return;
        end
        repeat (8) @(negedge clk);
        got[0] = uart_tx;
        for (int i = 1; i < 10; i++) begin
            repeat (16) @(negedge clk);
            got[i] = uart_tx;
        end
        chk(name, 32'(got), 32'({1'b1, exp, 1'b0}));
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (16) @(negedge clk);
        end
        uart_rx = stop;
        repeat (16) @(negedge clk);
        uart_rx = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    typedef struct {
        bit          wr;
        logic [1:0]  idx;
        logic [31:0] wd;
        logic [3:0]  wm;
        bit          chk_rd;
        logic [31:0] exp;
    } vec_t;

    vec_t        vt [14];
    logic [31:0] rd;
    int          lat, n;
    logic [7:0]  txb [10];

    initial begin
        vt[0]  = '{0, 2'd1, 32'h0,        4'h0, 1, 32'h2};
        vt[1]  = '{0, 2'd2, 32'h0,        4'h0, 1, 32'h364};
        vt[2]  = '{0, 2'd0, 32'h0,        4'h0, 1, 32'h0};
        vt[3]  = '{0, 2'd3, 32'h0,        4'h0, 1, 32'h0};
        vt[4]  = '{1, 2'd2, 32'h12345,    4'hF, 0, 32'h0};
        vt[5]  = '{0, 2'd2, 32'h0,        4'h0, 1, 32'h2345};
        vt[6]  = '{1, 2'd2, 32'hAB00,     4'h1, 0, 32'h0};
        vt[7]  = '{0, 2'd2, 32'h0,        4'h0, 1, 32'h2300};
        vt[8]  = '{1, 2'd3, 32'hFFFFFFFF, 4'hF, 0, 32'h0};
        vt[9]  = '{0, 2'd3, 32'h0,        4'h0, 1, 32'h0};
        vt[10] = '{1, 2'd0, 32'h77,       4'hE, 0, 32'h0};
        vt[11] = '{0, 2'd1, 32'h0,        4'h0, 1, 32'h2};
        vt[12] = '{1, 2'd2, 32'h3,        4'h3, 0, 32'h0};
        vt[13] = '{0, 2'd2, 32'h0,        4'h0, 1, 32'h3};
        txb = '{8'h3C, 8'h01, 8'h80, 8'hFF, 8'h00, 8'hA5, 8'h5A, 8'h0F, 8'hF0, 8'hC3};

        #1 rst = 1'b0;
        #2;
        chk("rst_done", 32'(bus_done), 0);
        chk("rst_rdata", bus_rdata, 0);
        chk("rst_tx", 32'(uart_tx), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            bus_xfer(vt[i].wr, vt[i].idx, vt[i].wd, vt[i].wm, rd, lat);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 1);
            if (vt[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
        end

        // DIV=3 is clamped to 4-cycle bits; 0x01 has bit0=1 so the low run is the start bit alone.
        bus_xfer(1, 2'd0, 32'h01, 4'h1, rd, lat);
        n = 0;
        while (uart_tx !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        n = 0;
        while (uart_tx === 1'b0 && n < 200) begin n++; @(negedge clk); end
        chk("div_min_start_len", 32'(n), 4);
        repeat (60) @(negedge clk);

        bus_xfer(1, 2'd2, 32'h10, 4'h3, rd, lat);
        bus_xfer(1, 2'd0, 32'h55, 4'h1, rd, lat);
        chk("tx55_lat", 32'(lat), 1);
        check_frame("tx55_frame", 8'h55);
        repeat (20) @(negedge clk);

        fork
            begin
                for (int i = 0; i < 10; i++) check_frame($sformatf("fifo_frame%0d", i), txb[i]);
            end
            begin
                for (int i = 0; i < 9; i++) begin
                    bus_xfer(1, 2'd0, 32'(txb[i]), 4'h1, rd, lat);
                    chk($sformatf("fifo_wr%0d_lat", i), 32'(lat), 1);
                end
                bus_xfer(0, 2'd1, 32'h0, 4'h0, rd, lat);
                chk("fifo_full_status", rd, 32'h5);
                bus_xfer(1, 2'd0, 32'(txb[9]), 4'h1, rd, lat);
                chk("stall_withheld", 32'(lat > 1 && lat < 200), 1);
                chk("stall_release_at_pop", 32'(uart_tx), 0);
            end
        join
        repeat (20) @(negedge clk);

        send_rx(8'hA3, 1'b1);
        bus_xfer(0, 2'd1, 32'h0, 4'h0, rd, lat); chk("rx_status_valid", rd, 32'hA);
        bus_xfer(0, 2'd0, 32'h0, 4'h0, rd, lat); chk("rx_data", rd, 32'h1A3);
        bus_xfer(0, 2'd1, 32'h0, 4'h0, rd, lat); chk("rx_status_clr", rd, 32'h2);
        bus_xfer(0, 2'd0, 32'h0, 4'h0, rd, lat); chk("rx_data_empty", rd, 32'h0);

        send_rx(8'h11, 1'b1);
        send_rx(8'h5C, 1'b1);
        bus_xfer(0, 2'd1, 32'h0, 4'h0, rd, lat); chk("ovr_status", rd, 32'h1A);
        bus_xfer(0, 2'd0, 32'h0, 4'h0, rd, lat); chk("ovr_data", rd, 32'h15C);
        bus_xfer(0, 2'd1, 32'h0, 4'h0, rd, lat); chk("ovr_status_clr", rd, 32'h2);

        send_rx(8'h42, 1'b0);
        bus_xfer(0, 2'd1, 32'h0, 4'h0, rd, lat); chk("badstop_status", rd, 32'h2);

        // Request held across a second edge with a new address: only the first is taken.
        @(negedge clk); bus_addr = 32'hC; bus_ren = 1'b1;
        @(negedge clk); chk("hold_pending", 32'(bus_done), 0); bus_addr = 32'h4;
        @(negedge clk); bus_ren = 1'b0;
        chk("hold_done", 32'(bus_done), 1);
        chk("hold_rdata", bus_rdata, 0);
        n = 0;
        repeat (6) begin @(negedge clk); if (bus_done) n++; end
        chk("hold_extra_done", 32'(n), 0);

        // Fill the FIFO behind a busy transmitter, then stall one more write.
        for (int i = 0; i < 9; i++) bus_xfer(1, 2'd0, 32'h0, 4'h1, rd, lat);
        @(negedge clk); bus_addr = 32'h0; bus_wdata = 32'hEE; bus_wmask = 4'h1; bus_wen = 1'b1;
        @(negedge clk); bus_wen = 1'b0;
        repeat (10) @(negedge clk);
        chk("stall_pre_done", 32'(bus_done), 0);
        chk("midframe_tx_low", 32'(uart_tx), 0);
        #2 rst = 1'b0;
        #1;
        chk("abort_tx", 32'(uart_tx), 1);
        chk("abort_done", 32'(bus_done), 0);
        @(negedge clk); rst = 1'b1;
        n = 0;
        repeat (40) begin @(negedge clk); if (bus_done || !uart_tx) n++; end
        chk("abort_quiet", 32'(n), 0);
        bus_xfer(0, 2'd2, 32'h0, 4'h0, rd, lat); chk("abort_div", rd, 32'h364);
        bus_xfer(0, 2'd1, 32'h0, 4'h0, rd, lat); chk("abort_status", rd, 32'h2);

        @(negedge clk); bus_addr = 32'h4; bus_ren = 1'b1;
        @(negedge clk); bus_ren = 1'b0;
        @(negedge clk);
        chk("rstdone_pre", 32'(bus_done), 1);
        #2 rst = 1'b0;
        #1;
        chk("rstdone_done", 32'(bus_done), 0);
        chk("rstdone_rdata", bus_rdata, 0);
        @(negedge clk); rst = 1'b1;
        bus_xfer(0, 2'd1, 32'h0, 4'h0, rd, lat);
        chk("post_rst_lat", 32'(lat), 1);
        chk("post_rst_status", rd, 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_uart.md
BUS_UART -- requirements
Module: bus_uart

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter DIV_RESET, default 868, baud divisor after reset (clk cycles per bit).
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-004 SHALL have ports: rst  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports: bus_addr  in  32  byte address; only [3:2] decoded.
REQ-006 SHALL have ports: bus_wdata  in  32  write data, byte lanes already aligned by initiator.
REQ-007 SHALL have ports: bus_wmask  in  4  byte-lane write enables.
REQ-008 SHALL have ports: bus_wen / bus_ren  in  1 each  request strobes, pre-gated by the address decoder.
REQ-009 SHALL have ports: bus_rdata  out  32  read data, valid while bus_done=1.
REQ-010 SHALL have ports: bus_done  out  1  completion, one cycle per accepted request.
REQ-011 SHALL have ports: uart_tx  out  1  serial out, idle high; uart_rx  in  1  asynchronous serial in.

Function
REQ-012 SHALL accept a request on a rising edge where (bus_ren|bus_wen)=1 and responder is IDLE or bus_done=1; otherwise the request is ignored (initiator holds it).
REQ-013 SHALL assert bus_done exactly one cycle after acceptance (latency 1), except REQ-017 stall; bus_done low at all other times.
REQ-014 SHALL capture addr[3:2], wdata, wmask, direction at acceptance; later bus input changes SHALL not affect the in-flight response.
REQ-015 SHALL decode registers: 0 DATA, 1 STATUS, 2 DIV, 3 reserved (reads 0, writes ignored).
REQ-016 SHALL on DATA write with wmask[0]=1 push wdata[7:0] into TX FIFO; wmask[0]=0 completes with no push.
REQ-017 SHALL stall a DATA write while TX FIFO full: bus_done withheld until an entry frees, push and bus_done in the same cycle.
REQ-018 SHALL on DATA read return {23'b0, rx_valid, rx_byte} and clear rx_valid and rx_overrun on completion; rx_byte=0 when empty.
REQ-019 SHALL on STATUS read return bit0 tx_full, bit1 tx_empty, bit2 tx_busy, bit3 rx_valid, bit4 rx_overrun, others 0; no side effects.
REQ-020 SHALL on DIV write update DIV[7:0]/[15:8] per wmask[0]/[1]; upper bits ignored; DIV reads zero-extended; values <4 SHALL be treated as 4.
REQ-021 SHALL transmit 8N1 LSB first: start 0, 8 data, stop 1, each DIV cycles; TX FSM states IDLE, START, DATA, STOP.
REQ-022 SHALL pop TX FIFO on IDLE->START when non-empty; back-to-back bytes SHALL have no idle gap beyond the stop bit.
REQ-023 SHALL handle a simultaneous push and pop on full FIFO as space freed then pushed (stall released same cycle).
REQ-024 SHALL synchronise uart_rx through 2 flops; RX FSM IDLE, START, DATA, STOP; start confirmed at DIV/2, data sampled at bit centres.
REQ-025 SHALL on valid stop bit load rx_byte, set rx_valid; if rx_valid already set SHALL overwrite and set rx_overrun; bad stop bit discards byte.
REQ-026 SHALL sample DIV at frame start; a DIV write mid-frame affects only the next frame.
REQ-027 SHALL wrap FIFO pointers modulo FIFO_DEPTH with an extra wrap bit for full/empty.

Reset
REQ-028 SHALL on rst=0 asynchronously clear: bus_done=0, bus_rdata=0, uart_tx=1, FIFO empty, DIV=DIV_RESET, rx_valid=0, rx_overrun=0, both FSMs IDLE.
REQ-029 SHALL abort any in-flight request or frame on reset without completion; first request after release follows REQ-012.

Structure
REQ-030 SHALL place register indices, STATUS bit positions and FSM state enums in package bus_uart_pkg.
REQ-031 SHALL implement the TX FIFO as sub-module uart_tx_fifo (push, pop, full, empty, count).

Verification
REQ-032 SHALL cover: DIV write 0x10 mask 0011, then DATA write 0x55 -> bus_done 1 cycle later; uart_tx start at 16-cycle bits, pattern 1,0,1,0,1,0,1,0, stop.
REQ-033 SHALL cover: 9 DATA writes, FIFO_DEPTH=8, TX busy -> 9th bus_done withheld until first pop, then asserted; all 9 bytes transmitted in order.
REQ-034 SHALL cover: drive 0xA3 on uart_rx at DIV=16 -> STATUS bit3=1; DATA read returns 0x1A3; subsequent STATUS read bit3=0.
REQ-035 SHALL cover: two RX bytes without read -> STATUS bit4=1, DATA returns second byte, overrun cleared after read.
REQ-036 SHALL cover: ren held high across two cycles with addr change -> only one accepted per done; read of reg 3 returns 0.
REQ-037 SHALL cover: rst low mid-frame and mid-stall -> uart_tx=1, bus_done=0 immediately, DIV=868.
